// File: rtl/occ_link_ctrl.sv
// ============================================================================
//  Module   : occ_link_ctrl
//  Purpose  : Per-lane link bring-up and supervision sequencer for one OCC
//             PHY instance. Resets the PHY receiver, waits for PHY ready,
//             requests a comma resync, waits for alignment and then declares
//             the link up. While up it watches encoding and elastic-buffer
//             errors and restarts the sequence on loss of lock or on too
//             many encoding errors inside one observation window.
//  Ports    :
//     clk_i              controller clock
//     rst_n_i            asynchronous active-low reset
//     en_i               link enable (0 forces DISABLED)
//     clr_cnt_i          synchronous clear of both diagnostic counters
//     phy_rx_rdy_i       PHY RX ready
//     phy_tx_rdy_i       PHY TX ready
//     phy_rx_synced_i    PHY comma aligned / elastic buffer synced
//     phy_rx_enc_err_i   8b10b code or disparity error this cycle
//     phy_rx_buf_err_i   elastic buffer over/underflow this cycle
//     phy_rx_rst_o       PHY RX reset, active-high
//     phy_rx_resync_o    one-cycle resync request
//     link_up_o          link usable by the packet layer
//     state_o            encoded FSM state
//     retry_cnt_o        HOLDOFF entries, saturating
//     err_cnt_o          encoding-error cycles seen in UP, saturating
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module occ_link_ctrl #(
   parameter int g_RST_CYCLES    = 16,
   parameter int g_RDY_TIMEOUT   = 4096,
   parameter int g_ERR_WINDOW    = 65536,
   parameter int g_ERR_THRESHOLD = 4,
   parameter int g_HOLDOFF       = 256
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic        clr_cnt_i,
   input  logic        phy_rx_rdy_i,
   input  logic        phy_tx_rdy_i,
   input  logic        phy_rx_synced_i,
   input  logic        phy_rx_enc_err_i,
   input  logic        phy_rx_buf_err_i,
   output logic        phy_rx_rst_o,
   output logic        phy_rx_resync_o,
   output logic        link_up_o,
   output logic [2:0]  state_o,
   output logic [15:0] retry_cnt_o,
   output logic [15:0] err_cnt_o
);

   // ---------------------------------------------------------------------
   // State encoding
   // ---------------------------------------------------------------------
   localparam logic [2:0] S_DISABLED  = 3'd0;
   localparam logic [2:0] S_RESET     = 3'd1;
   localparam logic [2:0] S_WAIT_RDY  = 3'd2;
   localparam logic [2:0] S_RESYNC    = 3'd3;
   localparam logic [2:0] S_WAIT_SYNC = 3'd4;
   localparam logic [2:0] S_UP        = 3'd5;
   localparam logic [2:0] S_HOLDOFF   = 3'd6;

   // One shared state timer covers every timed state, so it is sized for
   // the longest of them.
   localparam int c_TMR_MAX0 = (g_RST_CYCLES > g_RDY_TIMEOUT) ? g_RST_CYCLES : g_RDY_TIMEOUT;
   localparam int c_TMR_MAX  = (c_TMR_MAX0 > g_HOLDOFF) ? c_TMR_MAX0 : g_HOLDOFF;
   localparam int c_TMR_W    = $clog2(c_TMR_MAX + 1);

   localparam logic [c_TMR_W-1:0] c_RST_LAST  = c_TMR_W'(g_RST_CYCLES - 1);
   localparam logic [c_TMR_W-1:0] c_RDY_LAST  = c_TMR_W'(g_RDY_TIMEOUT - 1);
   localparam logic [c_TMR_W-1:0] c_HOLD_LAST = c_TMR_W'(g_HOLDOFF - 1);

   localparam int                 c_WIN_W    = $clog2(g_ERR_WINDOW);
   localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(g_ERR_WINDOW - 1);

   // Window count never exceeds threshold-1 while staying in UP; the
   // extra bit lets the "this cycle included" value reach the threshold.
   localparam int                  c_WCNT_W = $clog2(g_ERR_THRESHOLD + 1);
   localparam logic [c_WCNT_W:0]   c_THRESH = (c_WCNT_W + 1)'(g_ERR_THRESHOLD);

   // ---------------------------------------------------------------------
   // Registers and wires
   // ---------------------------------------------------------------------
   logic [2:0]          r_state;
   logic [2:0]          w_nxt;
   logic [c_TMR_W-1:0]  r_tmr;
   logic                w_timed;
   logic [c_WIN_W-1:0]  r_win_tmr;
   logic [c_WCNT_W-1:0] r_win_cnt;
   logic [c_WCNT_W:0]   w_win_eff;
   logic                w_win_expire;
   logic                w_stay_up;
   logic                w_hold_entry;
   logic                r_rx_rst;
   logic                r_resync;
   logic                r_link_up;
   logic [15:0]         r_retry_cnt;
   logic [15:0]         r_err_cnt;

   // Window count including an error in the current cycle; the count was
   // already zeroed at the previous window boundary, so an error in the
   // first cycle of a new window counts as one there.
   assign w_win_eff    = {1'b0, r_win_cnt} + {{c_WCNT_W{1'b0}}, phy_rx_enc_err_i};
   assign w_win_expire = (r_win_tmr == c_WIN_LAST);
   assign w_stay_up    = (r_state == S_UP) && (w_nxt == S_UP);
   assign w_hold_entry = (w_nxt == S_HOLDOFF) && (r_state != S_HOLDOFF);
   assign w_timed      = (r_state == S_RESET) || (r_state == S_WAIT_RDY) ||
                         (r_state == S_WAIT_SYNC) || (r_state == S_HOLDOFF);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_nxt = r_state;
      if (!en_i) begin
         w_nxt = S_DISABLED;
      end else begin
         case (r_state)
            S_DISABLED: w_nxt = S_RESET;
            S_RESET: begin
               if (r_tmr == c_RST_LAST) w_nxt = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
               if (phy_rx_rdy_i && phy_tx_rdy_i) w_nxt = S_RESYNC;
               else if (r_tmr == c_RDY_LAST)     w_nxt = S_HOLDOFF;
            end
            S_RESYNC: w_nxt = S_WAIT_SYNC;
            S_WAIT_SYNC: begin
               if (!phy_rx_rdy_i)              w_nxt = S_HOLDOFF;
               else if (phy_rx_synced_i)       w_nxt = S_UP;
               else if (r_tmr == c_RDY_LAST)   w_nxt = S_HOLDOFF;
            end
            S_UP: begin
               if (!phy_rx_rdy_i || !phy_rx_synced_i) w_nxt = S_HOLDOFF;
               else if (phy_rx_buf_err_i)             w_nxt = S_RESYNC;
               else if (w_win_eff >= c_THRESH)        w_nxt = S_HOLDOFF;
            end
            S_HOLDOFF: begin
               if (r_tmr == c_HOLD_LAST) w_nxt = S_RESET;
            end
            default: w_nxt = S_DISABLED;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // State, timers and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= S_DISABLED;
         r_tmr     <= '0;
         r_win_tmr <= '0;
         r_win_cnt <= '0;
         r_rx_rst  <= 1'b1;
         r_resync  <= 1'b0;
         r_link_up <= 1'b0;
      end else begin
         r_state <= w_nxt;

         // Timer restarts on every state change and only runs in timed states.
         if ((w_nxt != r_state) || !w_timed) r_tmr <= '0;
         else                                r_tmr <= r_tmr + 1'b1;

         // Error window only lives while UP is held; any exit or re-entry
         // starts a fresh window.
         if (w_stay_up) begin
            if (w_win_expire) begin
               r_win_tmr <= '0;
               r_win_cnt <= '0;
            end else begin
               r_win_tmr <= r_win_tmr + 1'b1;
               r_win_cnt <= w_win_eff[c_WCNT_W-1:0];
            end
         end else begin
            r_win_tmr <= '0;
            r_win_cnt <= '0;
         end

         // Outputs follow the state being entered so they line up with state_o.
         r_rx_rst  <= (w_nxt == S_DISABLED) || (w_nxt == S_RESET);
         r_resync  <= (w_nxt == S_RESYNC);
         r_link_up <= (w_nxt == S_UP);
      end
   end

   // ---------------------------------------------------------------------
   // Diagnostic counters (clear beats increment)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_retry_cnt <= '0;
         r_err_cnt   <= '0;
      end else if (clr_cnt_i) begin
         r_retry_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_hold_entry && (r_retry_cnt != 16'hFFFF))
            r_retry_cnt <= r_retry_cnt + 16'd1;
         if ((r_state == S_UP) && phy_rx_enc_err_i && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign phy_rx_rst_o    = r_rx_rst;
   assign phy_rx_resync_o = r_resync;
   assign link_up_o       = r_link_up;
   assign state_o         = r_state;
   assign retry_cnt_o     = r_retry_cnt;
   assign err_cnt_o       = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_occ_link_ctrl.sv
// ============================================================================
//  Module   : tb_occ_link_ctrl
//  Purpose  : Self-checking bench for occ_link_ctrl. Two instances share one
//             stimulus stream: instance 0 uses the bring-up/timeout settings
//             with a short error window and a threshold of 4, instance 1 has
//             a threshold above its window so it can stay up under constant
//             encoding errors. A behavioural model tracks each instance.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_occ_link_ctrl;

   localparam int D0_R = 16, D0_T = 4096, D0_W = 64, D0_TH = 4,  D0_H = 256;
   localparam int D1_R = 4,  D1_T = 64,   D1_W = 32, D1_TH = 64, D1_H = 8;

   logic clk_i = 1'b0;
   logic rst_n_i, en_i, clr_cnt_i;
   logic phy_rx_rdy_i, phy_tx_rdy_i, phy_rx_synced_i, phy_rx_enc_err_i, phy_rx_buf_err_i;

   logic        rx_rst0, resync0, up0, rx_rst1, resync1, up1;
   logic [2:0]  st0, st1;
   logic [15:0] rc0, ec0, rc1, ec1;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk_i = ~clk_i;

   occ_link_ctrl #(.g_RST_CYCLES(D0_R), .g_RDY_TIMEOUT(D0_T), .g_ERR_WINDOW(D0_W),
                   .g_ERR_THRESHOLD(D0_TH), .g_HOLDOFF(D0_H)) u_dut0 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .clr_cnt_i(clr_cnt_i),
      .phy_rx_rdy_i(phy_rx_rdy_i), .phy_tx_rdy_i(phy_tx_rdy_i),
      .phy_rx_synced_i(phy_rx_synced_i), .phy_rx_enc_err_i(phy_rx_enc_err_i),
      .phy_rx_buf_err_i(phy_rx_buf_err_i), .phy_rx_rst_o(rx_rst0),
      .phy_rx_resync_o(resync0), .link_up_o(up0), .state_o(st0),
      .retry_cnt_o(rc0), .err_cnt_o(ec0));

   occ_link_ctrl #(.g_RST_CYCLES(D1_R), .g_RDY_TIMEOUT(D1_T), .g_ERR_WINDOW(D1_W),
                   .g_ERR_THRESHOLD(D1_TH), .g_HOLDOFF(D1_H)) u_dut1 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .clr_cnt_i(clr_cnt_i),
      .phy_rx_rdy_i(phy_rx_rdy_i), .phy_tx_rdy_i(phy_tx_rdy_i),
      .phy_rx_synced_i(phy_rx_synced_i), .phy_rx_enc_err_i(phy_rx_enc_err_i),
      .phy_rx_buf_err_i(phy_rx_buf_err_i), .phy_rx_rst_o(rx_rst1),
      .phy_rx_resync_o(resync1), .link_up_o(up1), .state_o(st1),
      .retry_cnt_o(rc1), .err_cnt_o(ec1));

   // ---------------------------------------------------------------------
   // Behavioural model: per instance, the current state, how long it has
   // been there, how long it has been up, errors in the current window and
   // the two counters.
   // ---------------------------------------------------------------------
   int m_st[2], m_age[2], m_upk[2], m_wcnt[2], m_retry[2], m_err[2];

   function automatic int p_r(input int i);  return (i == 0) ? D0_R  : D1_R;  endfunction
   function automatic int p_t(input int i);  return (i == 0) ? D0_T  : D1_T;  endfunction
   function automatic int p_w(input int i);  return (i == 0) ? D0_W  : D1_W;  endfunction
   function automatic int p_th(input int i); return (i == 0) ? D0_TH : D1_TH; endfunction
   function automatic int p_h(input int i);  return (i == 0) ? D0_H  : D1_H;  endfunction

   // Errors in the current window including this cycle; a window starts
   // every p_w cycles counted from UP entry.
   function automatic int m_weff(input int i);
      int base;
      base = ((m_upk[i] % p_w(i)) == 0) ? 0 : m_wcnt[i];
      return base + (phy_rx_enc_err_i ? 1 : 0);
   endfunction

   function automatic int m_next(input int i);
      if (!en_i) return 0;
      case (m_st[i])
         0: return 1;
         1: return (m_age[i] == p_r(i) - 1) ? 2 : 1;
         2: begin
            if (phy_rx_rdy_i && phy_tx_rdy_i) return 3;
            if (m_age[i] == p_t(i) - 1)       return 6;
            return 2;
         end
         3: return 4;
         4: begin
            if (!phy_rx_rdy_i)          return 6;
            if (phy_rx_synced_i)        return 5;
            if (m_age[i] == p_t(i) - 1) return 6;
            return 4;
         end
         5: begin
            if (!phy_rx_rdy_i || !phy_rx_synced_i) return 6;
            if (phy_rx_buf_err_i)                  return 3;
            if (m_weff(i) >= p_th(i))              return 6;
            return 5;
         end
         6: return (m_age[i] == p_h(i) - 1) ? 1 : 6;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 2; i++) begin
            m_st[i] <= 0; m_age[i] <= 0; m_upk[i] <= 0;
            m_wcnt[i] <= 0; m_retry[i] <= 0; m_err[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_st[i]   <= m_next(i);
            m_age[i]  <= (m_next(i) == m_st[i]) ? m_age[i] + 1 : 0;
            m_upk[i]  <= (m_st[i] == 5 && m_next(i) == 5) ? m_upk[i] + 1 : 0;
            m_wcnt[i] <= (m_st[i] == 5 && m_next(i) == 5) ? m_weff(i) : 0;
            if (clr_cnt_i) begin
               m_retry[i] <= 0;
               m_err[i]   <= 0;
            end else begin
               if (m_next(i) == 6 && m_st[i] != 6 && m_retry[i] < 65535)
                  m_retry[i] <= m_retry[i] + 1;
               if (m_st[i] == 5 && phy_rx_enc_err_i && m_err[i] < 65535)
                  m_err[i] <= m_err[i] + 1;
            end
         end
      end
   end

   function automatic logic [37:0] m_pack(input int i);
      return {3'(m_st[i]), (m_st[i] <= 1), (m_st[i] == 3), (m_st[i] == 5),
              16'(m_retry[i]), 16'(m_err[i])};
   endfunction

   task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_i) begin
      chk("dut0_vs_model", {st0, rx_rst0, resync0, up0, rc0, ec0}, m_pack(0));
      chk("dut1_vs_model", {st1, rx_rst1, resync1, up1, rc1, ec1}, m_pack(1));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic enc_pulse;
      phy_rx_enc_err_i = 1'b1;
      tick(1);
      phy_rx_enc_err_i = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Directed stimulus with hand-computed literal expectations
   // ---------------------------------------------------------------------
   initial begin
      rst_n_i = 1'b0; en_i = 1'b0; clr_cnt_i = 1'b0;
      phy_rx_rdy_i = 1'b0; phy_tx_rdy_i = 1'b0; phy_rx_synced_i = 1'b0;
      phy_rx_enc_err_i = 1'b0; phy_rx_buf_err_i = 1'b0;
      tick(3);
      chk("reset_outputs", 38'({st0, rx_rst0, resync0, up0, rc0, ec0}),
          {3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
      rst_n_i = 1'b1;
      tick(2);
      chk("disabled_hold", 38'(st0), 38'(0));

      // 1. bring-up
      en_i = 1'b1;
      tick(1);
      chk("reset_entry", 38'({st0, rx_rst0}), 38'({3'd1, 1'b1}));
      tick(15);
      chk("reset_16th", 38'({st0, rx_rst0}), 38'({3'd1, 1'b1}));
      tick(1);
      chk("wait_rdy", 38'({st0, rx_rst0}), 38'({3'd2, 1'b0}));
      tick(13);
      phy_rx_rdy_i = 1'b1; phy_tx_rdy_i = 1'b1;
      tick(1);
      chk("resync_pulse", 38'({st0, resync0}), 38'({3'd3, 1'b1}));
      tick(1);
      chk("wait_sync", 38'({st0, resync0}), 38'({3'd4, 1'b0}));
      tick(4);
      phy_rx_synced_i = 1'b1;
      tick(1);
      chk("link_up", 38'({st0, up0, rc0}), 38'({3'd5, 1'b1, 16'd0}));

      // 3. error threshold: windows of 64 cycles from UP entry
      tick(5);  enc_pulse();   // k=5
      tick(9);  enc_pulse();   // k=15
      tick(9);  enc_pulse();   // k=25
      tick(44); enc_pulse();   // k=70
      tick(9);  enc_pulse();   // k=80
      tick(9);  enc_pulse();   // k=90
      chk("six_errs_up", 38'({st0, up0, ec0}), 38'({3'd5, 1'b1, 16'd6}));
      tick(37);                // next sample k=128, a new window
      phy_rx_enc_err_i = 1'b1;
      tick(3);
      chk("three_in_window", 38'(st0), 38'(5));
      tick(1);
      phy_rx_enc_err_i = 1'b0;
      chk("four_errs_holdoff", 38'({st0, up0, rc0, ec0}), 38'({3'd6, 1'b0, 16'd1, 16'd10}));
      tick(255);
      chk("holdoff_256th", 38'(st0), 38'(6));
      tick(1);
      chk("reset_after_hold", 38'(st0), 38'(1));
      tick(19);
      chk("up_again", 38'(st0), 38'(5));

      // 4. buffer error
      phy_rx_buf_err_i = 1'b1;
      tick(1);
      phy_rx_buf_err_i = 1'b0;
      chk("buf_resync", 38'({st0, resync0, rc0}), 38'({3'd3, 1'b1, 16'd1}));
      tick(1);
      chk("buf_wait_sync", 38'({st0, resync0}), 38'({3'd4, 1'b0}));
      tick(1);
      chk("buf_back_up", 38'({st0, up0, rc0}), 38'({3'd5, 1'b1, 16'd1}));

      // 5. disable during WAIT_SYNC, then clear on HOLDOFF entry
      phy_rx_buf_err_i = 1'b1;
      tick(1);
      phy_rx_buf_err_i = 1'b0;
      phy_rx_synced_i  = 1'b0;
      tick(2);
      chk("in_wait_sync", 38'(st0), 38'(4));
      en_i = 1'b0;
      tick(1);
      chk("disable", 38'({st0, rx_rst0, rc0}), 38'({3'd0, 1'b1, 16'd1}));
      en_i = 1'b1;
      tick(17);
      chk("reen_wait_rdy", 38'(st0), 38'(2));
      tick(2);
      phy_rx_rdy_i = 1'b0; clr_cnt_i = 1'b1;
      tick(1);
      clr_cnt_i = 1'b0;
      chk("clr_vs_holdoff", 38'({st0, rc0, ec0}), 38'({3'd6, 16'd0, 16'd0}));

      // 2. timeout loops with rdy never asserted
      en_i = 1'b0; clr_cnt_i = 1'b1; phy_tx_rdy_i = 1'b0;
      tick(1);
      clr_cnt_i = 1'b0; en_i = 1'b1;
      tick(17);
      chk("to_wait_rdy", 38'({st0, rc0}), 38'({3'd2, 16'd0}));
      tick(4095);
      chk("wait_rdy_4096th", 38'(st0), 38'(2));
      tick(1);
      chk("timeout_1", 38'({st0, rc0}), 38'({3'd6, 16'd1}));
      tick(255);
      chk("holdoff_len", 38'(st0), 38'(6));
      tick(1);
      chk("reset_reentry", 38'(st0), 38'(1));
      tick(4112);
      chk("timeout_2", 38'({st0, rc0}), 38'({3'd6, 16'd2}));
      tick(4368);
      chk("timeout_3", 38'({st0, rc0}), 38'({3'd6, 16'd3}));

      // 6. saturation on instance 1 under constant encoding errors
      phy_rx_rdy_i = 1'b1; phy_tx_rdy_i = 1'b1; phy_rx_synced_i = 1'b1;
      phy_rx_enc_err_i = 1'b1;
      tick(65560);
      chk("err_saturate", 38'({st1, up1, ec1}), 38'({3'd5, 1'b1, 16'hFFFF}));
      phy_rx_enc_err_i = 1'b0;
      tick(3);

      // asynchronous reset mid-UP, checked before any clock edge
      chk("pre_rst_up", 38'(st1), 38'(5));
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("async_rst1", 38'({st1, rx_rst1, resync1, up1, rc1, ec1}),
          {3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
      chk("async_rst0", 38'({st0, rx_rst0, resync0, up0, rc0, ec0}),
          {3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
      tick(1);
      rst_n_i = 1'b1;
      tick(1);
      chk("release_sync", 38'({st0, st1}), 38'({3'd1, 3'd1}));
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
